// File: rtl/plic_clkgate_if.sv
// Bundle of configuration, wake-request and gate-status signals between the
// requester/config side and the PLIC clock-gating controller.
interface plic_clkgate_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned STAT_W  = 16
);
  logic               cfg_gate_en;
  logic [CNT_W-1:0]   cfg_idle_thresh;
  logic [NUM_REQ-1:0] req;
  logic               busy;
  logic [NUM_REQ-1:0] ack;
  logic               clk_en;
  logic               gated;
  logic [STAT_W-1:0]  gate_events;

  modport master (
    output cfg_gate_en, cfg_idle_thresh, req, busy,
    input  ack, clk_en, gated, gate_events
  );

  modport slave (
    input  cfg_gate_en, cfg_idle_thresh, req, busy,
    output ack, clk_en, gated, gate_events
  );
endinterface

// File: rtl/plic_clkgate_ctrl.sv
// Idle-based clock-gating controller: drops the gated-domain clock enable after a
// programmable quiet period and re-enables it, with a settle delay, on wake requests.
module plic_clkgate_ctrl #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned WAKE_CYCLES = 2,
  parameter int unsigned STAT_W      = 16
) (
  input  logic           clk,
  input  logic           rst,
  plic_clkgate_if.slave  bus
);

  localparam int unsigned WAKE_W = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
  localparam logic [WAKE_W-1:0] WAKE_LAST = WAKE_W'(WAKE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_IDLE,
    ST_GATED,
    ST_WAKE
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  idle_cnt_q, idle_cnt_d;
  logic [WAKE_W-1:0] wake_cnt_q, wake_cnt_d;
  logic [STAT_W-1:0] gate_events_q, gate_events_d;
  logic              clk_en_q, clk_en_d;
  logic              gated_q, gated_d;

  logic              quiet;
  logic [CNT_W-1:0]  thresh_eff;

  always_comb begin
    quiet         = ~|bus.req & ~bus.busy;
    thresh_eff    = (bus.cfg_idle_thresh == '0) ? CNT_W'(1) : bus.cfg_idle_thresh;
    state_d       = state_q;
    idle_cnt_d    = idle_cnt_q;
    wake_cnt_d    = wake_cnt_q;
    gate_events_d = gate_events_q;

    case (state_q)
      ST_RUN: begin
        if (bus.cfg_gate_en && quiet) begin
          state_d    = ST_IDLE;
          idle_cnt_d = CNT_W'(1);
        end else begin
          idle_cnt_d = '0;
        end
      end
      ST_IDLE: begin
        // A wake condition arriving on the threshold cycle wins over gating.
        if (!quiet || !bus.cfg_gate_en) begin
          state_d    = ST_RUN;
          idle_cnt_d = '0;
        end else if (idle_cnt_q >= thresh_eff) begin
          state_d = ST_GATED;
          if (gate_events_q != '1) gate_events_d = gate_events_q + STAT_W'(1);
        end else if (idle_cnt_q != '1) begin
          idle_cnt_d = idle_cnt_q + CNT_W'(1);
        end
      end
      ST_GATED: begin
        if ((|bus.req) || bus.busy || !bus.cfg_gate_en) begin
          state_d    = ST_WAKE;
          wake_cnt_d = '0;
        end
      end
      ST_WAKE: begin
        if (wake_cnt_q == WAKE_LAST) begin
          state_d  = ST_RUN;
          idle_cnt_d = '0;
        end else begin
          wake_cnt_d = wake_cnt_q + WAKE_W'(1);
        end
      end
      default: state_d = ST_RUN;
    endcase

    clk_en_d = (state_d != ST_GATED);
    gated_d  = (state_d == ST_GATED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_RUN;
      idle_cnt_q    <= '0;
      wake_cnt_q    <= '0;
      gate_events_q <= '0;
      clk_en_q      <= 1'b1;
      gated_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      idle_cnt_q    <= idle_cnt_d;
      wake_cnt_q    <= wake_cnt_d;
      gate_events_q <= gate_events_d;
      clk_en_q      <= clk_en_d;
      gated_q       <= gated_d;
    end
  end

  assign bus.ack         = (state_q == ST_RUN) ? bus.req : '0;
  assign bus.clk_en      = clk_en_q;
  assign bus.gated       = gated_q;
  assign bus.gate_events = gate_events_q;

endmodule

// File: tb/tb_plic_clkgate_ctrl.sv
// Self-checking bench for plic_clkgate_ctrl: directed scenarios plus randomized traffic
// compared every cycle against a quiet-run-length reference model.
module tb_plic_clkgate_ctrl;

  localparam int unsigned NUM_REQ     = 4;
  localparam int unsigned CNT_W       = 8;
  localparam int unsigned WAKE_CYCLES = 2;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  bit   chk_en;

  plic_clkgate_if #(.NUM_REQ(NUM_REQ), .CNT_W(CNT_W), .STAT_W(16)) bus ();
  plic_clkgate_if #(.NUM_REQ(NUM_REQ), .CNT_W(CNT_W), .STAT_W(2))  bus2 ();

  assign bus2.cfg_gate_en     = bus.cfg_gate_en;
  assign bus2.cfg_idle_thresh = bus.cfg_idle_thresh;
  assign bus2.req             = bus.req;
  assign bus2.busy            = bus.busy;

  plic_clkgate_ctrl #(.NUM_REQ(NUM_REQ), .CNT_W(CNT_W), .WAKE_CYCLES(WAKE_CYCLES), .STAT_W(16))
    dut (.clk(clk), .rst(rst), .bus(bus));

  plic_clkgate_ctrl #(.NUM_REQ(NUM_REQ), .CNT_W(CNT_W), .WAKE_CYCLES(WAKE_CYCLES), .STAT_W(2))
    dut_sat (.clk(clk), .rst(rst), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: awake (run = consecutive quiet cycles), gated, or waking.
  typedef enum {M_AWAKE, M_GATED, M_WAKE} mode_t;
  mode_t m_mode;
  int    m_run;
  int    m_wk;
  int    m_ev;

  always @(posedge clk) begin
    int th;
    bit q;
    th = (bus.cfg_idle_thresh == 0) ? 1 : int'(bus.cfg_idle_thresh);
    q  = (bus.req == 0) && !bus.busy;
    if (rst) begin
      m_mode = M_AWAKE; m_run = 0; m_wk = 0; m_ev = 0;
    end else begin
      case (m_mode)
        M_AWAKE: begin
          if (bus.cfg_gate_en && q) begin
            if (m_run >= th) begin
              m_mode = M_GATED; m_run = 0; m_ev++;
            end else begin
              m_run++;
            end
          end else begin
            m_run = 0;
          end
        end
        M_GATED: begin
          if (bus.req != 0 || bus.busy || !bus.cfg_gate_en) begin
            m_mode = M_WAKE; m_wk = 0;
          end
        end
        default: begin
          m_wk++;
          if (m_wk == WAKE_CYCLES) begin
            m_mode = M_AWAKE; m_run = 0;
          end
        end
      endcase
    end
  end

  always @(posedge clk) begin
    logic [NUM_REQ-1:0] exp_ack;
    #1;
    if (chk_en) begin
      exp_ack = (m_mode == M_AWAKE && m_run == 0) ? bus.req : '0;
      chk("model_clk_en", 64'(bus.clk_en), 64'(m_mode != M_GATED));
      chk("model_gated", 64'(bus.gated), 64'(m_mode == M_GATED));
      chk("model_ack", 64'(bus.ack), 64'(exp_ack));
      chk("model_gate_events", 64'(bus.gate_events), 64'((m_ev > 65535) ? 65535 : m_ev));
      chk("model_sat_clk_en", 64'(bus2.clk_en), 64'(m_mode != M_GATED));
      chk("model_sat_ack", 64'(bus2.ack), 64'(exp_ack));
      chk("model_sat_gate_events", 64'(bus2.gate_events), 64'((m_ev > 3) ? 3 : m_ev));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    chk_en   = 1'b0;
    rst      = 1'b1;
    bus.cfg_gate_en     = 1'b0;
    bus.cfg_idle_thresh = 8'd4;
    bus.req             = '0;
    bus.busy            = 1'b0;

    // Reset
    step(2);
    chk_en = 1'b1;
    chk("rst_clk_en", 64'(bus.clk_en), 64'd1);
    chk("rst_gated", 64'(bus.gated), 64'd0);
    chk("rst_ack", 64'(bus.ack), 64'd0);
    chk("rst_gate_events", 64'(bus.gate_events), 64'd0);
    rst = 1'b0;

    // Gate after quiet period with thresh=4
    bus.cfg_gate_en = 1'b1;
    step(4);
    chk("t2_clk_en_before", 64'(bus.clk_en), 64'd1);
    step(1);
    chk("t2_clk_en_gated", 64'(bus.clk_en), 64'd0);
    chk("t2_gated", 64'(bus.gated), 64'd1);
    chk("t2_gate_events", 64'(bus.gate_events), 64'd1);

    // Wake on req[2]
    bus.req = 4'b0100;
    step(1);
    chk("t3_clk_en_wake", 64'(bus.clk_en), 64'd1);
    chk("t3_ack_wake0", 64'(bus.ack), 64'd0);
    step(1);
    chk("t3_ack_wake1", 64'(bus.ack), 64'd0);
    step(1);
    chk("t3_ack_run", 64'(bus.ack), 64'b0100);
    bus.req = '0;

    // Busy on third quiet cycle aborts the idle countdown
    step(2);
    bus.busy = 1'b1;
    step(1);
    chk("t4_no_gate", 64'(bus.clk_en), 64'd1);
    bus.busy = 1'b0;
    step(4);
    chk("t4_fresh_before", 64'(bus.clk_en), 64'd1);
    step(1);
    chk("t4_fresh_gated", 64'(bus.clk_en), 64'd0);
    chk("t4_gate_events", 64'(bus.gate_events), 64'd2);

    // Disabling gating while gated forces the clock back on
    bus.cfg_gate_en = 1'b0;
    step(1);
    chk("t5_wake_clk_en", 64'(bus.clk_en), 64'd1);
    step(2);
    for (int i = 0; i < 100; i++) begin
      step(1);
      chk("t5_forced_on", 64'(bus.clk_en), 64'd1);
    end
    chk("t5_gate_events", 64'(bus.gate_events), 64'd2);

    // thresh=0 behaves as 1; saturation of a 2-bit counter
    bus.cfg_idle_thresh = 8'd0;
    bus.cfg_gate_en     = 1'b1;
    step(1);
    chk("t6_thresh0_idle", 64'(bus.clk_en), 64'd1);
    step(1);
    chk("t6_thresh0_gated", 64'(bus.clk_en), 64'd0);
    for (int i = 0; i < 3; i++) begin
      bus.busy = 1'b1;
      step(1);
      bus.busy = 1'b0;
      step(4);
    end
    chk("t6_gated_again", 64'(bus.gated), 64'd1);
    chk("t6_events_wide", 64'(bus.gate_events), 64'd6);
    chk("t6_events_sat", 64'(bus2.gate_events), 64'd3);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 49) == 0) bus.cfg_idle_thresh = 8'($urandom_range(0, 6));
      if ($urandom_range(0, 19) == 0) bus.cfg_gate_en = ($urandom_range(0, 7) != 0);
      bus.busy = ($urandom_range(0, 9) == 0);
      bus.req  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : '0;
      step(1);
    end
    rst = 1'b0;
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
